color_seq_checker: RTL and testbench

COLOR_SEQ_CHECKER -- requirements
Module: color_seq_checker

---
 rtl/color_seq_checker.sv | 147 ++++++++++++++
 tb/tb_color_seq_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/color_seq_checker.sv
// Color-sequence memory game: extend, play back, then check player entries.
// Optional INPUT_TIMEOUT_EN macro fails a round after TIMEOUT_CYCLES idle cycles.
module color_seq_checker #(
   parameter int MAX_LEN        = 16,
   parameter int SHOW_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] rand_in,
   input  logic       start,
   input  logic       key_valid,
   input  logic [1:0] key_color,
   output logic [1:0] expect_color,
   output logic       show_valid,
   output logic [4:0] round,
   output logic       busy,
   output logic       win,
   output logic       fail,
   output logic       done
);

   localparam int IW = $clog2(MAX_LEN);
   localparam int CW = $clog2(SHOW_CYCLES + 1);
   localparam logic [CW-1:0] SHOW_END = CW'(SHOW_CYCLES);
   localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE, EXTEND, SHOW, WAIT_IN, WIN, FAIL, DONE
   } state_t;

   state_t        state, state_nxt;
   logic [4:0]    len, len_nxt;
   logic [IW-1:0] show_idx, show_idx_nxt;
   logic [IW-1:0] in_idx, in_idx_nxt;
   logic [CW-1:0] show_cnt, show_cnt_nxt;
   logic [1:0]    seq [MAX_LEN];
   logic          seq_we;
   logic          last_show, last_in, key_ok, tmo;

   assign last_show = (5'(show_idx) == len - 5'd1);
   assign last_in   = (5'(in_idx) == len - 5'd1);
   assign key_ok    = (key_color == seq[in_idx]);

`ifdef INPUT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] timer;

   // Held at zero outside WAIT_IN, so entering WAIT_IN starts from zero.
   always_ff @(posedge clk) begin
      if (reset || state != WAIT_IN || key_valid)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end

   assign tmo = (state == WAIT_IN) && !key_valid && (timer == TMO_LAST);
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      len_nxt      = len;
      show_idx_nxt = show_idx;
      in_idx_nxt   = in_idx;
      show_cnt_nxt = show_cnt;
      seq_we       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt    = EXTEND;
               len_nxt      = '0;
               show_idx_nxt = '0;
               in_idx_nxt   = '0;
            end
         end
         EXTEND: begin
            seq_we       = 1'b1;
            len_nxt      = len + 5'd1;
            show_idx_nxt = '0;
            show_cnt_nxt = '0;
            state_nxt    = SHOW;
         end
         SHOW: begin
            if (show_cnt == SHOW_END) begin
               show_cnt_nxt = '0;
               if (last_show) begin
                  state_nxt  = WAIT_IN;
                  in_idx_nxt = '0;
               end else begin
                  show_idx_nxt = show_idx + 1'b1;
               end
            end else begin
               show_cnt_nxt = show_cnt + 1'b1;
            end
         end
         WAIT_IN: begin
            unique case (1'b1)
               key_valid && !key_ok:
                  state_nxt = FAIL;
               key_valid && key_ok && !last_in:
                  in_idx_nxt = in_idx + 1'b1;
               key_valid && key_ok && last_in:
                  state_nxt = (len == LEN_MAX) ? WIN : EXTEND;
               tmo:
                  state_nxt = FAIL;
               default: ;
            endcase
         end
         WIN, FAIL: state_nxt = DONE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         len      <= '0;
         show_idx <= '0;
         in_idx   <= '0;
         show_cnt <= '0;
      end else begin
         state    <= state_nxt;
         len      <= len_nxt;
         show_idx <= show_idx_nxt;
         in_idx   <= in_idx_nxt;
         show_cnt <= show_cnt_nxt;
      end
   end

   // Entries at or beyond len are never read, so storage needs no reset.
   always_ff @(posedge clk) begin
      if (seq_we)
         seq[len[IW-1:0]] <= rand_in;
   end

   assign show_valid   = (state == SHOW) && (show_cnt != SHOW_END);
   assign expect_color = show_valid ? seq[show_idx] : 2'b00;
   assign round        = len;
   assign busy         = (state != IDLE) && (state != DONE);
   assign win          = (state == WIN);
   assign fail         = (state == FAIL);
   assign done         = (state == DONE);

endmodule

// File: tb/tb_color_seq_checker.sv
// Scoreboard bench for color_seq_checker (MAX_LEN=4, SHOW_CYCLES=2).
// Playback and win/fail pulses are queued at stimulus time and popped by a monitor.
module tb_color_seq_checker;

   localparam int SC = 2;

   logic       clk = 1'b0;
   logic       reset, start, key_valid;
   logic [1:0] rand_in, key_color;
   logic [1:0] expect_color;
   logic       show_valid, busy, win, fail, done;
   logic [4:0] round;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       sv;
      logic [1:0] col;
      logic       w;
      logic       f;
      logic [4:0] rnd;
   } ev_t;

   ev_t exp_q [$];
   logic [1:0] s [4];

   color_seq_checker #(
      .MAX_LEN(4), .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .rand_in(rand_in),
      .start(start), .key_valid(key_valid),
      .key_color(key_color), .expect_color(expect_color),
      .show_valid(show_valid), .round(round), .busy(busy),
      .win(win), .fail(fail), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      ev_t a, e;
      if (show_valid === 1'b1 || win === 1'b1 || fail === 1'b1) begin
         a = {show_valid, expect_color, win, fail, round};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event act=%b exp=none", a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL event act=%b exp=%b", a, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic push(input logic sv, input logic [1:0] col,
                       input logic w, input logic f, input logic [4:0] r);
      ev_t e;
      e = {sv, col, w, f, r};
      exp_q.push_back(e);
   endtask

   task automatic all_zero(input string nm);
      chk(nm, {4'h0, expect_color, show_valid, round, busy, win, fail, done},
          16'h0000);
   endtask

   task automatic key(input logic [1:0] c);
      key_color = c;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called in the EXTEND cycle; returns in the first WAIT_IN cycle.
   task automatic play(input int r, input bit noisy);
      for (int i = 0; i < r; i++)
         repeat (SC) push(1'b1, s[i], 1'b0, 1'b0, 5'(r));
      for (int i = 0; i <= (SC + 1) * r; i++) begin
         if (noisy) begin
            key_valid = i[0];
            key_color = s[0];
         end
         @(negedge clk);
      end
      key_valid = 1'b0;
      chk("wait_in", {9'h0, busy, show_valid, round},
          {9'h0, 1'b1, 1'b0, 5'(r)});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; key_valid = 1'b0;
      rand_in = 2'b00; key_color = 2'b00;
      repeat (3) @(negedge clk);
      all_zero("reset_state");
      reset = 1'b0;
      @(negedge clk);
      all_zero("idle_state");

      // Game A: round 1 red->yellow, then fail in round 2.
      rand_in = 2'b10; s[0] = 2'b10;
      pulse_start();
      play(1, 1'b0);
      rand_in = 2'b01; s[1] = 2'b01;
      key(2'b10);
      play(2, 1'b0);
      key(2'b10);
      push(1'b0, 2'b00, 1'b0, 1'b1, 5'd2);
      key(2'b11);
      @(negedge clk);
      chk("fail_done", {11'h0, done, busy, fail, win, show_valid},
          {11'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      chk("fail_round", {11'h0, round}, 16'd2);

      // Game B: start and key together, noisy SHOW, full win.
      rand_in = 2'b11; s[0] = 2'b11;
      start = 1'b1; key_valid = 1'b1; key_color = 2'b00;
      @(negedge clk);
      start = 1'b0; key_valid = 1'b0;
      play(1, 1'b0);
      rand_in = 2'b00; s[1] = 2'b00;
      key(2'b11);
      play(2, 1'b1);
      key(2'b11);
      rand_in = 2'b01; s[2] = 2'b01;
      key(2'b00);
      play(3, 1'b0);
      key(2'b11); key(2'b00);
      rand_in = 2'b10; s[3] = 2'b10;
      key(2'b01);
      play(4, 1'b0);
      key(2'b11); key(2'b00); key(2'b01);
      push(1'b0, 2'b00, 1'b1, 1'b0, 5'd4);
      key(2'b10);
      @(negedge clk);
      chk("win_done", {11'h0, done, busy, fail, win, show_valid},
          {11'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      chk("win_round", {11'h0, round}, 16'd4);
      key(2'b01);
      @(negedge clk);
      chk("done_key_ignored", {10'h0, done, round},
          {10'h0, 1'b1, 5'd4});

      // Restart from DONE.
      rand_in = 2'b01; s[0] = 2'b01;
      pulse_start();
      play(1, 1'b0);
`ifdef INPUT_TIMEOUT_EN
      push(1'b0, 2'b00, 1'b0, 1'b1, 5'd1);
      repeat (9) @(negedge clk);
      chk("timeout_done", {14'h0, done, busy}, {14'h0, 1'b1, 1'b0});
`else
      repeat (100) @(negedge clk);
      chk("no_timeout", {9'h0, done, busy, round},
          {9'h0, 1'b0, 1'b1, 5'd1});
`endif

      // Reset in the middle of playback, together with start and key.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rand_in = 2'b11;
      pulse_start();
      repeat (SC) push(1'b1, 2'b11, 1'b0, 1'b0, 5'd1);
      repeat (SC) @(negedge clk);
      reset = 1'b1; start = 1'b1;
      key_valid = 1'b1; key_color = 2'b11;
      @(negedge clk);
      all_zero("reset_mid_show");
      @(negedge clk);
      all_zero("reset_priority");
      reset = 1'b0; start = 1'b0; key_valid = 1'b0;
      @(negedge clk);
      all_zero("after_reset");

      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
